// File: rtl/pc_ship_placement_sequencer_if.sv
// Bundle between the computer-side ship placement sequencer and its users.
// The master drives the request and the random sources; the slave (the
// sequencer) returns the PC board and the status flags.
interface pc_ship_placement_sequencer_if #(
    parameter int BOARD = 5
);
    logic                       start;
    logic [2:0]                 numBarcos;
    logic [3:0]                 filaRandom;
    logic [3:0]                 columnaRandom;
    logic                       orientRandom;
    logic [BOARD*BOARD*3-1:0]   tablero;
    logic [BOARD*BOARD-1:0]     ocupado;
    logic                       busy;
    logic                       barcosColocados;
    logic                       error;
    logic [6:0]                 intentos;

    modport master (
        output start, numBarcos, filaRandom, columnaRandom, orientRandom,
        input  tablero, ocupado, busy, barcosColocados, error, intentos
    );

    modport slave (
        input  start, numBarcos, filaRandom, columnaRandom, orientRandom,
        output tablero, ocupado, busy, barcosColocados, error, intentos
    );
endinterface

// File: rtl/pc_ship_placement_sequencer.sv
// Places the computer's ships on the BOARD x BOARD grid, largest first.
// Each ship draws a random origin/orientation, is checked one cell per
// cycle for bounds and overlap, and only then written one cell per cycle,
// so a rejected attempt never leaves partial cells behind.
module pc_ship_placement_sequencer #(
    parameter int BOARD     = 5,
    parameter int MAX_SHIP  = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    pc_ship_placement_sequencer_if.slave  bus
);

    localparam int CELLS = BOARD * BOARD;
    localparam int IDX_W = $clog2(CELLS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    logic [2:0]          state_r, state_s;
    logic [2:0]          size_r, size_s;
    logic [3:0]          f_r, f_s;
    logic [3:0]          c_r, c_s;
    logic                o_r, o_s;
    logic [2:0]          k_r, k_s;
    logic [CELLS*3-1:0]  tablero_r, tablero_s;
    logic [CELLS-1:0]    ocupado_r, ocupado_s;
    logic [6:0]          intentos_r, intentos_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                error_r, error_s;

    // Cell addressed by the current ship at offset k. Coordinates are kept
    // 5 bits wide so an out-of-range row/column never wraps into the board.
    logic [4:0]          row_s, col_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    idx_s;
    logic [6:0]          base_s;
    logic                reject_s;
    logic                last_cell_s;

    assign row_s       = {1'b0, f_r} + (o_r ? {2'b00, k_r} : 5'd0);
    assign col_s       = {1'b0, c_r} + (o_r ? 5'd0 : {2'b00, k_r});
    assign in_range_s  = (row_s < 5'(BOARD)) && (col_s < 5'(BOARD));
    assign idx_s       = IDX_W'(row_s) * IDX_W'(BOARD) + IDX_W'(col_s);
    assign base_s      = 7'(idx_s) * 7'd3;
    assign reject_s    = !in_range_s || ocupado_r[idx_s];
    assign last_cell_s = (k_r == size_r - 3'd1);

    assign busy_s  = (state_s == ST_SAMPLE) || (state_s == ST_CHECK) || (state_s == ST_WRITE);
    assign done_s  = (state_s == ST_DONE);
    assign error_s = (state_s == ST_FAIL);

    // Next-state and datapath update for the placement controller.
    always_comb begin
        state_s    = state_r;
        size_s     = size_r;
        f_s        = f_r;
        c_s        = c_r;
        o_s        = o_r;
        k_s        = k_r;
        tablero_s  = tablero_r;
        ocupado_s  = ocupado_r;
        intentos_s = intentos_r;

        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.start) begin
                    tablero_s  = '0;
                    ocupado_s  = '0;
                    intentos_s = 7'd0;
                    k_s        = 3'd0;
                    if (bus.numBarcos == 3'd0) begin
                        state_s = ST_DONE;
                    end else if (32'(bus.numBarcos) > 32'(MAX_SHIP)) begin
                        state_s = ST_FAIL;
                    end else begin
                        size_s  = bus.numBarcos;
                        state_s = ST_SAMPLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_SAMPLE: begin
                f_s        = bus.filaRandom;
                c_s        = bus.columnaRandom;
                o_s        = bus.orientRandom;
                intentos_s = intentos_r + 7'd1;
                k_s        = 3'd0;
                state_s    = ST_CHECK;
            end

            ST_CHECK: begin
                if (reject_s) begin
                    k_s = 3'd0;
                    if (intentos_r == 7'(MAX_TRIES)) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s = ST_SAMPLE;
                    end
                end else if (last_cell_s) begin
                    k_s     = 3'd0;
                    state_s = ST_WRITE;
                end else begin
                    k_s = k_r + 3'd1;
                end
            end

            ST_WRITE: begin
                tablero_s[base_s +: 3] = size_r;
                ocupado_s[idx_s]       = 1'b1;
                if (last_cell_s) begin
                    k_s = 3'd0;
                    if (size_r == 3'd1) begin
                        state_s = ST_DONE;
                    end else begin
                        size_s     = size_r - 3'd1;
                        intentos_s = 7'd0;
                        state_s    = ST_SAMPLE;
                    end
                end else begin
                    k_s = k_r + 3'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial board.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            size_r     <= 3'd0;
            f_r        <= 4'd0;
            c_r        <= 4'd0;
            o_r        <= 1'b0;
            k_r        <= 3'd0;
            tablero_r  <= '0;
            ocupado_r  <= '0;
            intentos_r <= 7'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            size_r     <= size_s;
            f_r        <= f_s;
            c_r        <= c_s;
            o_r        <= o_s;
            k_r        <= k_s;
            tablero_r  <= tablero_s;
            ocupado_r  <= ocupado_s;
            intentos_r <= intentos_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    assign bus.tablero         = tablero_r;
    assign bus.ocupado         = ocupado_r;
    assign bus.busy            = busy_r;
    assign bus.barcosColocados = done_r;
    assign bus.error           = error_r;
    assign bus.intentos        = intentos_r;

endmodule

// File: tb/tb_pc_ship_placement_sequencer.sv
// Bench for the PC ship placement sequencer: an attempt-level model of the
// placement rules is compared with the DUT on every cycle, and directed
// scenarios pin the model with hand-computed board values and latencies.
`timescale 1ns/1ps
module tb_pc_ship_placement_sequencer;

    localparam int BOARD     = 5;
    localparam int CELLS     = BOARD * BOARD;
    localparam int MAX_SHIP  = 5;
    localparam int MAX_TRIES = 4;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;
    localparam int M_FAIL = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_ship_placement_sequencer_if #(.BOARD(BOARD)) bus ();

    pc_ship_placement_sequencer #(
        .BOARD(BOARD), .MAX_SHIP(MAX_SHIP), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: one placement attempt is evaluated as a whole when it is drawn;
    // m_left counts the edges until its outcome takes effect.
    int m_mode = M_IDLE;
    int m_size = 0;
    int m_tries = 0;
    int m_intentos = 0;
    int m_left = 0;
    int m_reject_k = -1;
    int m_f = 0, m_c = 0, m_o = 0;
    int m_board [CELLS];

    int q_f[$], q_c[$], q_o[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_reject(input int f, input int c, input int o, input int size);
        for (int k = 0; k < size; k++) begin
            int r;
            int cc;
            r  = f + (o != 0 ? k : 0);
            cc = c + (o != 0 ? 0 : k);
            if (f >= BOARD || c >= BOARD || r >= BOARD || cc >= BOARD) return k;
            if (m_board[r*BOARD + cc] != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [CELLS*3-1:0] exp_tab();
        logic [CELLS*3-1:0] v;
        v = '0;
        for (int i = 0; i < CELLS; i++) v[3*i +: 3] = 3'(m_board[i]);
        return v;
    endfunction

    function automatic logic [CELLS-1:0] exp_ocu();
        logic [CELLS-1:0] v;
        v = '0;
        for (int i = 0; i < CELLS; i++) v[i] = (m_board[i] != 0);
        return v;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < CELLS; i++) m_board[i] = 0;
    endtask

    task automatic model_step();
        int nb;
        nb = int'(bus.numBarcos);
        if (!reset) begin
            clear_board();
            m_mode = M_IDLE; m_intentos = 0; m_tries = 0; m_left = 0;
        end else if (m_mode != M_BUSY) begin
            if (bus.start) begin
                clear_board();
                m_intentos = 0; m_tries = 0; m_left = 0;
                if (nb == 0) m_mode = M_DONE;
                else if (nb > MAX_SHIP) m_mode = M_FAIL;
                else begin m_mode = M_BUSY; m_size = nb; end
            end
        end else if (m_left == 0) begin
            m_f = int'(bus.filaRandom);
            m_c = int'(bus.columnaRandom);
            m_o = int'(bus.orientRandom);
            m_tries++;
            m_intentos = m_tries;
            m_reject_k = first_reject(m_f, m_c, m_o, m_size);
            m_left = (m_reject_k < 0) ? 2 * m_size : m_reject_k + 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_reject_k >= 0) begin
                    if (m_tries == MAX_TRIES) m_mode = M_FAIL;
                end else begin
                    for (int k = 0; k < m_size; k++)
                        m_board[(m_f + (m_o != 0 ? k : 0)) * BOARD + m_c + (m_o != 0 ? 0 : k)] = m_size;
                    if (m_size == 1) m_mode = M_DONE;
                    else begin m_size--; m_tries = 0; m_intentos = 0; end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic qs(input int f, input int c, input int o);
        q_f.push_back(f); q_c.push_back(c); q_o.push_back(o);
    endtask

    // Directed samples go out only when the next edge draws a sample;
    // every other cycle carries junk that must be ignored.
    task automatic drive_inputs();
        if (m_mode == M_BUSY && m_left == 0 && q_f.size() > 0) begin
            bus.filaRandom    = 4'(q_f.pop_front());
            bus.columnaRandom = 4'(q_c.pop_front());
            bus.orientRandom  = 1'(q_o.pop_front());
        end else if ($urandom_range(0, 3) == 0) begin
            bus.filaRandom    = 4'($urandom_range(0, 7));
            bus.columnaRandom = 4'($urandom_range(0, 7));
            bus.orientRandom  = 1'($urandom_range(0, 1));
        end else begin
            bus.filaRandom    = 4'($urandom_range(0, 4));
            bus.columnaRandom = 4'($urandom_range(0, 4));
            bus.orientRandom  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run(input int nb, input bit stray, input int budget, output int lat);
        int n;
        bit fin;
        bus.numBarcos = 3'(nb);
        bus.start = 1'b1;
        drive_inputs();
        n = 0; fin = 1'b0; lat = -1;
        while (!fin) begin
            cycle();
            n++;
            bus.start = 1'b0;
            if (stray && m_mode == M_BUSY && (n == 5 || $urandom_range(0, 9) == 0)) begin
                bus.start = 1'b1;
                bus.numBarcos = 3'($urandom_range(0, 7));
            end
            drive_inputs();
            if (!bus.busy && (bus.barcosColocados || bus.error)) begin
                fin = 1'b1;
                lat = n - 1;
            end else if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout nb=%0d actual=%0d cycles required=finish", nb, n);
                fin = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    // Every cycle: flags and try counter always, the board whenever idle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     80'(bus.busy),            80'(m_mode == M_BUSY));
            chk("done",     80'(bus.barcosColocados), 80'(m_mode == M_DONE));
            chk("error",    80'(bus.error),           80'(m_mode == M_FAIL));
            chk("intentos", 80'(bus.intentos),        80'(m_intentos));
            if (m_mode != M_BUSY) begin
                chk("tablero", 80'(bus.tablero), 80'(exp_tab()));
                chk("ocupado", 80'(bus.ocupado), 80'(exp_ocu()));
            end
        end
    end

    initial begin
        int lat;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.numBarcos = 3'd0;
        bus.filaRandom = 4'd0;
        bus.columnaRandom = 4'd0;
        bus.orientRandom = 1'b0;
        clear_board();

        // Reset state
        cycle(); cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_tablero", 80'(bus.tablero), 80'd0);
        chk("rst_ocupado", 80'(bus.ocupado), 80'd0);
        chk("rst_flags", 80'({bus.busy, bus.barcosColocados, bus.error}), 80'd0);
        chk("rst_intentos", 80'(bus.intentos), 80'd0);
        reset = 1'b1;
        cycle();

        // Single ship at (2,3) horizontal
        qs(2, 3, 0);
        run(1, 1'b0, 100, lat);
        chk("single_lat", 80'(lat), 80'd3);
        chk("single_ocupado", 80'(bus.ocupado), 80'h0002000);
        chk("single_tablero", 80'(bus.tablero), 80'h1 << 39);
        chk("single_intentos", 80'(bus.intentos), 80'd1);
        chk("single_done", 80'(bus.barcosColocados), 80'd1);

        // Overlap retry: one reject costs SAMPLE + one CHECK cycle
        qs(0, 0, 0); qs(0, 1, 0); qs(4, 4, 0);
        run(2, 1'b0, 100, lat);
        chk("retry_lat", 80'(lat), 80'd10);
        chk("retry_cells01", 80'(bus.tablero[5:0]), 80'o22);
        chk("retry_cell24", 80'(bus.tablero[74:72]), 80'd1);
        chk("retry_intentos", 80'(bus.intentos), 80'd2);

        // Bounds: column overflow at k=4, row 7 does not wrap to row 2
        qs(0, 1, 0); qs(0, 0, 0); qs(1, 0, 0); qs(2, 0, 0); qs(3, 0, 0);
        qs(7, 4, 1); qs(4, 0, 0);
        run(5, 1'b0, 200, lat);
        chk("bounds_lat", 80'(lat), 80'd43);
        chk("bounds_ocupado", 80'(bus.ocupado), 80'h119DFF);
        chk("bounds_intentos", 80'(bus.intentos), 80'd2);

        // Full placement with stray start pulses while busy
        qs(0, 0, 0); qs(1, 0, 0); qs(2, 0, 0); qs(3, 0, 0); qs(4, 0, 0);
        run(5, 1'b1, 200, lat);
        chk("full_lat", 80'(lat), 80'd35);
        chk("full_ocupado", 80'(bus.ocupado), 80'h119DFF);
        chk("full_rowcol0", 80'({bus.tablero[62:60], bus.tablero[47:45], bus.tablero[32:30],
                                 bus.tablero[17:15], bus.tablero[2:0]}), 80'o12345);

        // Exhaustion: row 7 every time
        qs(7, 0, 0); qs(7, 1, 0); qs(7, 2, 1); qs(7, 3, 0);
        run(3, 1'b0, 100, lat);
        chk("exh_lat", 80'(lat), 80'd8);
        chk("exh_error", 80'(bus.error), 80'd1);
        chk("exh_flags", 80'({bus.busy, bus.barcosColocados}), 80'd0);
        chk("exh_tablero", 80'(bus.tablero), 80'd0);
        chk("exh_intentos", 80'(bus.intentos), 80'd4);

        // Degenerate counts
        run(0, 1'b0, 10, lat);
        chk("zero_lat", 80'(lat), 80'd0);
        run(6, 1'b0, 10, lat);
        chk("big_error", 80'({lat[3:0], bus.error}), 80'h1);

        // Reset during the WRITE of the size-4 ship
        qs(0, 0, 0); qs(1, 0, 0); qs(2, 0, 0); qs(3, 0, 0); qs(4, 0, 0);
        bus.numBarcos = 3'd5;
        bus.start = 1'b1;
        drive_inputs();
        for (int n = 0; n < 18; n++) begin
            cycle();
            bus.start = 1'b0;
            drive_inputs();
        end
        reset = 1'b0;
        cycle();
        chk("midrst_tablero", 80'(bus.tablero), 80'd0);
        chk("midrst_ocupado", 80'(bus.ocupado), 80'd0);
        chk("midrst_flags", 80'({bus.busy, bus.barcosColocados, bus.error}), 80'd0);
        chk("midrst_intentos", 80'(bus.intentos), 80'd0);
        reset = 1'b1;
        q_f.delete(); q_c.delete(); q_o.delete();
        cycle();
        qs(2, 3, 0);
        run(1, 1'b0, 100, lat);
        chk("restart_lat", 80'(lat), 80'd3);
        chk("restart_ocupado", 80'(bus.ocupado), 80'h0002000);

        // Randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            int nb;
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            run(nb, 1'b1, 600, lat);
            if ($urandom_range(0, 3) == 0) begin
                cycle();
                drive_inputs();
            end
        end

        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
